mdll_pd_filter: RTL and testbench
=================================

# mdll_pd_filter

Parametrised digital back end for the MDLL phase detector. It samples the synchronised lead/lag flags once per reference window and turns them into a saturating delay-line control code, with single-cycle up/dn step pulses and a lock indication. It runs entirely in the `clk_in` domain, replaces the fixed window decode of the earlier detector and adds a selectable filtering mode. It sits between the lead/lag synchroniser and the delay-line code decoder.

## Interface
Parameters:
- `CNT_W`, 4, width of the edge counter input.
- `MULT`, 10, multiplication factor; a window ends when `counter == MULT-1`.
- `CODE_W`, 6, width of the delay control code.
- `CODE_INIT`, 32, code value loaded at reset; must be ≤ 2^CODE_W−1.
- `VOTE_N`, 4, number of decisions per vote in mode 1; must be an even number ≥ 2.
- `LOCK_N`, 8, number of non-monotonic updates required to assert `locked`.

Ports:
- `clk_in`  in  1  block clock; all logic is in this domain.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  strobe enable; when low, strobes are suppressed.
- `mode`  in  1  0 = bang-bang (step on every decision); 1 = majority vote over `VOTE_N` decisions.
- `counter`  in  CNT_W  edge counter from the MDLL divider.
- `lead_s`  in  1  synchronised lead flag from the phase detector.
- `lag_s`  in  1  synchronised lag flag from the phase detector.
- `code`  out  CODE_W  delay-line control code.
- `up`  out  1  one-cycle pulse when `code` was incremented.
- `dn`  out  1  one-cycle pulse when `code` was decremented.
- `sat_hi`, `sat_lo`  out  1  `code` is at its maximum or minimum value.
- `locked`  out  1  lock indication.

## Operation
- **Strobe.** `strb = en && (counter == MULT-1)`. No state changes when there is no strobe, except for the mode-change rule below.
- **Decision at strobe.**
  - `lead_s & ~lag_s` gives UP (output clock leads, so add delay).
  - `lag_s & ~lead_s` gives DN.
  - Both high or both low gives HOLD.
- **Mode 0.** UP increments `code` by 1 and DN decrements it by 1. HOLD leaves `code` unchanged.
- **Mode 1.**
  - A signed accumulator `acc` (range ±VOTE_N) adds +1 for UP, −1 for DN and 0 for HOLD.
  - A vote counter `vcnt` counts from 0 to VOTE_N−1.
  - On the strobe where `vcnt == VOTE_N-1`, the final `acc` (including this decision) is evaluated:
    - `acc ≥ VOTE_N/2` steps up.
    - `acc ≤ −VOTE_N/2` steps down.
    - Otherwise the result is HOLD.
  - After that evaluation, `acc` and `vcnt` are cleared.
- **Saturation.** A step beyond 2^CODE_W−1 or below 0 is dropped: `code` is unchanged and no `up`/`dn` pulse is produced. `sat_hi` = (code == max) and `sat_lo` = (code == 0), both registered.
- **Lock detector.** It evaluates on every update event, meaning every strobe in mode 0 and every vote end in mode 1.
  - A step in the same direction as the previous step clears `lcnt`.
  - A HOLD, or a step opposite to the previous step, increments `lcnt`, saturating at LOCK_N.
  - `locked = (lcnt == LOCK_N)`.
  - A dropped saturated step counts as a same-direction step, so `lcnt` is cleared.
  - The previous direction is remembered across HOLDs.
- **Mode change.** If `mode` differs from its value in the previous cycle, `acc`, `vcnt` and `lcnt` are cleared on the next edge. `code` is kept.
- **Enable low.** `acc`, `vcnt`, `lcnt` and `code` all hold their values.
- **Reset.** Asserting `rst` at any time, including mid-vote, forces:
  - `code = CODE_INIT`
  - `up = dn = locked = 0`
  - `acc = vcnt = lcnt = 0`, and the previous direction set to none
  - `sat_hi`/`sat_lo` to values consistent with CODE_INIT

## Timing
- The strobe is evaluated in cycle t. The `code` update and the `up`/`dn` pulse are both visible in cycle t+1, so latency is 1 cycle.
- `up` and `dn` are high for exactly one cycle and are never high together.
- `sat_*` and `locked` change in the same cycle as `code`.
- Back-to-back strobes (`counter` held at MULT−1) are legal and give one update per cycle.
- Release of `rst` is asynchronous to the clock. The first strobe is honoured on the first edge after release.

## Structure
- Shared package `mdll_pkg`:
  - `dec_t` enum {DEC_HOLD, DEC_UP, DEC_DN}
  - `MODE_BB = 1'b0`, `MODE_VOTE = 1'b1`
- Sub-module `mdll_lock_det`: takes the update event and `dec_t` and produces `locked`. It is parametrised by LOCK_N.
- The top level contains the strobe logic, decision logic, vote accumulator and saturating code register.

## Test plan
- **Mode 0 single step.** Reset, then mode 0 with one strobe and lead_s=1, lag_s=0. Required: `code` goes 32→33 and `up`=1 for exactly one cycle at t+1.
- **Mode 1 vote.** Mode 1 with VOTE_N=4 and decisions DN, DN, HOLD, UP (acc=−1). Required: no step. Next vote DN, DN, DN, HOLD (acc=−3). Required: `code` 32→31 and `dn` pulse after the 4th strobe only.
- **Saturation.** Preset to 63 via CODE_INIT=63, then an UP strobe. Required: `code` stays 63, no `up` pulse, `sat_hi`=1, `lcnt` cleared.
- **Lock.** Mode 0 with 8 alternating UP/DN strobes. Required: `locked`=1 after the 8th update; one further UP following an UP clears `locked` on the next cycle.
- **Reset mid-vote.** Mode 1, two UP strobes, then `rst` pulsed between clock edges. Required: `code`=32, `acc`=0, and a full 4 fresh strobes are needed before any step.
- **Mode switch and enable.** A mode switch mid-vote clears `acc`/`lcnt` and keeps `code`. With `en`=0 and `counter`=9, no change occurs.

Source files
------------

// File: rtl/mdll_pkg.sv
// Shared types for the MDLL phase-detector back end: decision encoding,
// filter mode encoding and the lead/lag decision helper.
`default_nettype none

package mdll_pkg;

    typedef enum logic [1:0] {
        DEC_HOLD = 2'd0,
        DEC_UP   = 2'd1,
        DEC_DN   = 2'd2
    } dec_t;

    localparam logic MODE_BB   = 1'b0;
    localparam logic MODE_VOTE = 1'b1;

    // Output clock leading means the line needs more delay.
    function automatic dec_t lead_lag_decision(input logic lead, input logic lag);
        dec_t d;
        d = DEC_HOLD;
        if (lead && !lag)
            d = DEC_UP;
        else if (lag && !lead)
            d = DEC_DN;
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdll_lock_det.sv
// Lock detector: counts non-monotonic update events (holds and direction
// reversals) and flags lock once LOCK_N of them occur without a repeat step.
`default_nettype none

module mdll_lock_det
    import mdll_pkg::*;
#(
    parameter int LOCK_N = 8
) (
    input  logic clk_in,
    input  logic rst,
    input  logic clr,
    input  logic upd,
    input  logic drop,
    input  dec_t dec,
    output logic locked
);

    localparam int LCNT_W = $clog2(LOCK_N + 1);
    localparam logic [LCNT_W-1:0] c_lock_n = LCNT_W'(LOCK_N);
    localparam logic [LCNT_W-1:0] c_one    = LCNT_W'(1);

    logic [LCNT_W-1:0] r_lcnt;
    dec_t              r_prev;
    logic [LCNT_W-1:0] w_lcnt_inc;
    logic              w_repeat;

    assign w_lcnt_inc = (r_lcnt == c_lock_n) ? r_lcnt : r_lcnt + c_one;
    // A step dropped at a rail is treated like a repeated step.
    assign w_repeat   = (dec != DEC_HOLD) && (drop || (dec == r_prev));

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_lcnt <= '0;
            r_prev <= DEC_HOLD;
        end else if (clr) begin
            r_lcnt <= '0;
        end else if (upd) begin
            r_lcnt <= w_repeat ? '0 : w_lcnt_inc;
            if (dec != DEC_HOLD)
                r_prev <= dec;
        end
    end

    assign locked = (r_lcnt == c_lock_n);

endmodule

`default_nettype wire

// File: rtl/mdll_pd_filter.sv
// MDLL phase-detector filter: strobes lead/lag once per reference window and
// drives a saturating delay-line code in bang-bang or majority-vote mode.
`default_nettype none

module mdll_pd_filter
    import mdll_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int MULT      = 10,
    parameter int CODE_W    = 6,
    parameter int CODE_INIT = 32,
    parameter int VOTE_N    = 4,
    parameter int LOCK_N    = 8
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [CNT_W-1:0]  counter,
    input  logic              lead_s,
    input  logic              lag_s,
    output logic [CODE_W-1:0] code,
    output logic              up,
    output logic              dn,
    output logic              sat_hi,
    output logic              sat_lo,
    output logic              locked
);

    localparam int ACC_W  = $clog2(VOTE_N + 1) + 1;
    localparam int VCNT_W = $clog2(VOTE_N);

    localparam logic [CODE_W-1:0]       c_code_max  = '1;
    localparam logic [CODE_W-1:0]       c_code_init = CODE_W'(CODE_INIT);
    localparam logic [CODE_W-1:0]       c_code_one  = CODE_W'(1);
    localparam logic [CNT_W-1:0]        c_win_end   = CNT_W'(MULT - 1);
    localparam logic [VCNT_W-1:0]       c_vote_last = VCNT_W'(VOTE_N - 1);
    localparam logic [VCNT_W-1:0]       c_vcnt_one  = VCNT_W'(1);
    localparam logic signed [ACC_W-1:0] c_half      = ACC_W'(VOTE_N / 2);
    localparam logic signed [ACC_W-1:0] c_neg_half  = -c_half;

    logic                     r_mode_q;
    logic signed [ACC_W-1:0]  r_acc;
    logic [VCNT_W-1:0]        r_vcnt;
    logic [CODE_W-1:0]        r_code;
    logic                     r_up;
    logic                     r_dn;
    logic                     r_sat_hi;
    logic                     r_sat_lo;

    logic                     w_mode_chg;
    logic                     w_strb;
    dec_t                     w_dec;
    logic signed [ACC_W-1:0]  w_delta;
    logic signed [ACC_W-1:0]  w_acc_nxt;
    logic                     w_vote_end;
    logic                     w_upd;
    dec_t                     w_step;
    logic                     w_drop;
    logic                     w_inc;
    logic                     w_dec_code;
    logic [CODE_W-1:0]        w_code_nxt;

    // Unreset so a mode held through reset is not seen as a change afterwards.
    always_ff @(posedge clk_in) begin
        r_mode_q <= mode;
    end

    assign w_mode_chg = (mode != r_mode_q);
    assign w_strb     = en && (counter == c_win_end);
    assign w_dec      = lead_lag_decision(lead_s, lag_s);
    assign w_acc_nxt  = r_acc + w_delta;
    assign w_vote_end = (r_vcnt == c_vote_last);
    assign w_upd      = w_strb && !w_mode_chg && ((mode == MODE_BB) || w_vote_end);

    always_comb begin
        w_delta = '0;
        w_step  = DEC_HOLD;
        case (w_dec)
            DEC_UP:  w_delta = ACC_W'(1);
            DEC_DN:  w_delta = -ACC_W'(1);
            default: w_delta = '0;
        endcase
        if (mode == MODE_BB)
            w_step = w_dec;
        else if (w_acc_nxt >= c_half)
            w_step = DEC_UP;
        else if (w_acc_nxt <= c_neg_half)
            w_step = DEC_DN;
    end

    assign w_drop     = ((w_step == DEC_UP) && (r_code == c_code_max)) ||
                        ((w_step == DEC_DN) && (r_code == '0));
    assign w_inc      = w_upd && (w_step == DEC_UP) && !w_drop;
    assign w_dec_code = w_upd && (w_step == DEC_DN) && !w_drop;
    assign w_code_nxt = w_inc      ? r_code + c_code_one :
                        w_dec_code ? r_code - c_code_one : r_code;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_vcnt <= '0;
        end else if (w_mode_chg) begin
            r_acc  <= '0;
            r_vcnt <= '0;
        end else if (w_strb && (mode == MODE_VOTE)) begin
            if (w_vote_end) begin
                r_acc  <= '0;
                r_vcnt <= '0;
            end else begin
                r_acc  <= w_acc_nxt;
                r_vcnt <= r_vcnt + c_vcnt_one;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_code   <= c_code_init;
            r_up     <= 1'b0;
            r_dn     <= 1'b0;
            r_sat_hi <= (c_code_init == c_code_max);
            r_sat_lo <= (c_code_init == '0);
        end else begin
            r_code   <= w_code_nxt;
            r_up     <= w_inc;
            r_dn     <= w_dec_code;
            r_sat_hi <= (w_code_nxt == c_code_max);
            r_sat_lo <= (w_code_nxt == '0);
        end
    end

    mdll_lock_det #(
        .LOCK_N (LOCK_N)
    ) u_lock_det (
        .clk_in (clk_in),
        .rst    (rst),
        .clr    (w_mode_chg),
        .upd    (w_upd),
        .drop   (w_drop),
        .dec    (w_step),
        .locked (locked)
    );

    assign code   = r_code;
    assign up     = r_up;
    assign dn     = r_dn;
    assign sat_hi = r_sat_hi;
    assign sat_lo = r_sat_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdll_pd_filter.sv
// Bench for mdll_pd_filter: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural reference model.
`default_nettype none

module tb_mdll_pd_filter;

    localparam int MULT      = 10;
    localparam int CODE_INIT = 32;
    localparam int VOTE_N    = 4;
    localparam int LOCK_N    = 8;
    localparam int CODE_MAX  = 63;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic       en     = 1'b0;
    logic       mode   = 1'b0;
    logic [3:0] counter = 4'd0;
    logic       lead_s = 1'b0;
    logic       lag_s  = 1'b0;
    logic [5:0] code;
    logic       up, dn, sat_hi, sat_lo, locked;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int   m_code     = CODE_INIT;
    int   m_votes[$];
    int   m_lcnt     = 0;
    int   m_prevdir  = 0;
    logic m_prev_mode = 1'b0;
    logic m_up = 1'b0;
    logic m_dn = 1'b0;

    mdll_pd_filter #(
        .CNT_W     (4),
        .MULT      (MULT),
        .CODE_W    (6),
        .CODE_INIT (CODE_INIT),
        .VOTE_N    (VOTE_N),
        .LOCK_N    (LOCK_N)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .counter (counter),
        .lead_s  (lead_s),
        .lag_s   (lag_s),
        .code    (code),
        .up      (up),
        .dn      (dn),
        .sat_hi  (sat_hi),
        .sat_lo  (sat_lo),
        .locked  (locked)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_code    = CODE_INIT;
        m_votes.delete();
        m_lcnt    = 0;
        m_prevdir = 0;
        m_up      = 1'b0;
        m_dn      = 1'b0;
    endfunction

    // One clock edge of the filter as described by its rules.
    function automatic void model_edge();
        int d, step, sum;
        bit upd, drop;
        m_up = 1'b0;
        m_dn = 1'b0;
        if (rst) begin
            model_reset();
        end else if (mode != m_prev_mode) begin
            m_votes.delete();
            m_lcnt = 0;
        end else if (en && counter == 4'(MULT - 1)) begin
            d    = (lead_s && !lag_s) ? 1 : (lag_s && !lead_s) ? -1 : 0;
            upd  = 1'b0;
            step = 0;
            if (mode == 1'b0) begin
                upd  = 1'b1;
                step = d;
            end else begin
                m_votes.push_back(d);
                if (m_votes.size() == VOTE_N) begin
                    sum = 0;
                    foreach (m_votes[i]) sum += m_votes[i];
                    upd  = 1'b1;
                    step = (sum >= VOTE_N / 2) ? 1 : (sum <= -(VOTE_N / 2)) ? -1 : 0;
                    m_votes.delete();
                end
            end
            if (upd) begin
                drop = (step == 1 && m_code == CODE_MAX) || (step == -1 && m_code == 0);
                if (!drop && step != 0) begin
                    m_code += step;
                    m_up = (step == 1);
                    m_dn = (step == -1);
                end
                if (step != 0 && (drop || step == m_prevdir))
                    m_lcnt = 0;
                else if (m_lcnt < LOCK_N)
                    m_lcnt++;
                if (step != 0)
                    m_prevdir = step;
            end
        end
        m_prev_mode = mode;
    endfunction

    task automatic check_model();
        logic [10:0] act, exp;
        act = {code, up, dn, sat_hi, sat_lo, locked};
        exp = {6'(m_code), m_up, m_dn, 1'(m_code == CODE_MAX), 1'(m_code == 0),
               1'(m_lcnt == LOCK_N)};
        chk("model outputs {code,up,dn,sat_hi,sat_lo,locked}", int'(act), int'(exp));
    endtask

    task automatic cyc(input logic m, input logic e, input logic [3:0] c,
                       input logic ld, input logic lg);
        mode    = m;
        en      = e;
        counter = c;
        lead_s  = ld;
        lag_s   = lg;
        @(posedge clk_in);
        model_edge();
        #1;
        check_model();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic rst_pulse();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("reset code", int'(code), CODE_INIT);
        chk("reset up/dn/locked", int'({up, dn, locked}), 0);
    endtask

    typedef struct {
        logic       m;
        logic       e;
        logic [3:0] c;
        logic       ld;
        logic       lg;
        int         exp_code;
        logic       exp_up;
        logic       exp_dn;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 33, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 33, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 32, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 4'd9, 1'b1, 1'b1, 32, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 4'd9, 1'b1, 1'b0, 32, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 32, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 4'd9, 1'b0, 1'b1, 32, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 4'd9, 1'b0, 1'b1, 32, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 32, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 32, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 4'd9, 1'b0, 1'b1, 32, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 4'd9, 1'b0, 1'b1, 32, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 4'd9, 1'b0, 1'b1, 32, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 4'd9, 1'b1, 1'b1, 31, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 31, 1'b0, 1'b0};

        repeat (3) @(posedge clk_in);
        #1 rst = 1'b0;
        model_reset();
        chk("reset state {code,up,dn,sat_hi,sat_lo,locked}",
            int'({code, up, dn, sat_hi, sat_lo, locked}), CODE_INIT << 5);

        // Directed vectors: single step, enable low, mode switch, vote windows
        foreach (vecs[i]) begin
            cyc(vecs[i].m, vecs[i].e, vecs[i].c, vecs[i].ld, vecs[i].lg);
            chk($sformatf("vec%0d code", i), int'(code), vecs[i].exp_code);
            chk($sformatf("vec%0d up,dn", i), int'({up, dn}),
                int'({vecs[i].exp_up, vecs[i].exp_dn}));
        end

        // Reset mid-vote: a fresh full vote is needed afterwards
        cyc(1'b1, 1'b1, 4'd9, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 4'd9, 1'b1, 1'b0);
        rst_pulse();
        cyc(1'b1, 1'b1, 4'd9, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 4'd9, 1'b1, 1'b0);
        chk("post-reset half vote code", int'(code), 32);
        chk("post-reset half vote up", int'(up), 0);
        cyc(1'b1, 1'b1, 4'd9, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 4'd9, 1'b1, 1'b0);
        chk("post-reset full vote code", int'(code), 33);
        chk("post-reset full vote up", int'(up), 1);

        // Mode switch mid-vote clears the partial vote and keeps code
        cyc(1'b1, 1'b1, 4'd9, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 4'd9, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        chk("mode switch keeps code", int'(code), 33);
        cyc(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 4'd9, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 4'd9, 1'b1, 1'b0);
        chk("partial vote cleared by mode switch", int'(code), 33);

        // Lock: alternating steps, then repeated step breaks lock
        rst_pulse();
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 1'b1, 4'd9, (i % 2) == 0, (i % 2) == 1);
        // mode held at 1 since the earlier switch, so use bang-bang after a switch
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("not locked before 8 updates", int'(locked), 0);
            cyc(1'b0, 1'b1, 4'd9, (i % 2) == 0, (i % 2) == 1);
        end
        chk("locked after 8 alternating", int'(locked), 1);
        cyc(1'b0, 1'b1, 4'd9, 1'b1, 1'b0);
        chk("locked after UP reversal", int'(locked), 1);
        cyc(1'b0, 1'b1, 4'd9, 1'b1, 1'b0);
        chk("repeat UP clears locked", int'(locked), 0);
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
        chk("locked after 8 holds", int'(locked), 1);
        cyc(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        chk("mode switch clears locked", int'(locked), 0);

        // Saturation at the top rail
        cyc(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++)
            cyc(1'b0, 1'b1, 4'd9, 1'b1, 1'b0);
        chk("code at max", int'(code), CODE_MAX);
        chk("sat_hi at max", int'(sat_hi), 1);
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
        chk("locked on holds at max", int'(locked), 1);
        cyc(1'b0, 1'b1, 4'd9, 1'b1, 1'b0);
        chk("dropped UP code", int'(code), CODE_MAX);
        chk("dropped UP no pulse", int'(up), 0);
        chk("dropped UP clears locked", int'(locked), 0);

        // Randomized run against the reference model
        begin
            int   p_lead, p_lag;
            logic m;
            m = mode;
            p_lead = 50;
            p_lag  = 50;
            for (int i = 0; i < 4000; i++) begin
                if (i % 400 == 0) begin
                    case ($urandom % 3)
                        0: begin p_lead = 80; p_lag = 10; end
                        1: begin p_lead = 10; p_lag = 80; end
                        default: begin p_lead = 50; p_lag = 50; end
                    endcase
                end
                if ($urandom % 150 == 0) m = ~m;
                if ($urandom % 500 == 0) rst_pulse();
                cyc(m, ($urandom % 8) != 0,
                    ($urandom % 3 == 0) ? 4'd9 : 4'($urandom % 16),
                    ($urandom % 100) < p_lead, ($urandom % 100) < p_lag);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Pulses must never coincide.
    always @(negedge clk_in) begin
        if (!rst && up && dn) begin
            n_checks++;
            n_fail++;
            $display("FAIL up/dn exclusive: got up=%0b dn=%0b expected not both", up, dn);
        end
    end

endmodule

`default_nettype wire
